// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter : two-master round-robin arbiter onto one 256x32 SRAM port
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata
);

  logic req0, req1;
  logic grant0, grant1;
  logic issue_rd;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    // Gating with reset_n keeps the port quiet and both masters stalled in reset.
    grant0 = reset_n & req0 & (~req1 | last_grant);
    grant1 = reset_n & req1 & (~req0 | ~last_grant);
  end

  assign m0_waitrequest = ~reset_n | (req0 & ~grant0);
  assign m1_waitrequest = ~reset_n | (req1 & ~grant1);

  assign sram_chipselect = grant0 | grant1;
  assign sram_address    = grant1 ? m1_address    : m0_address;
  assign sram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign sram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign sram_write      = grant1 ? m1_write      : (grant0 & m0_write);

  // Read together with write is a write; it must not produce a response.
  assign issue_rd = grant1 ? (m1_read & ~m1_write) : (grant0 & m0_read & ~m0_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (sram_chipselect) begin
        last_grant <= grant1;
      end
      rd_pend <= issue_rd;
      if (issue_rd) begin
        rd_owner <= grant1;
      end
    end
  end

  assign m0_readdatavalid = rd_pend & ~rd_owner;
  assign m1_readdatavalid = rd_pend &  rd_owner;
  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// tb_sram_port_arbiter : directed self-checking bench with a behavioural SRAM
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [7:0]  sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write;
  logic [31:0] sram_writedata;
  logic [31:0] sram_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .BE_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_readdata(sram_readdata)
  );

  // Behavioural SRAM port: byte-lane writes, one-cycle registered reads.
  // Unwritten words read back a fixed pattern derived from their address.
  logic [31:0] mem [256];
  bit          written [256];

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return 32'h5A00_0000 | {24'h0, a};
  endfunction

  always @(posedge clk) begin
    if (sram_chipselect) begin
      if (sram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_byteenable[b]) mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
        end
        written[sram_address] <= 1'b1;
      end else begin
        sram_readdata <= written[sram_address] ? mem[sram_address] : dflt(sram_address);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [7:0] a,
                      input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  initial begin
    logic [7:0] idx0, idx1, prev_addr;
    logic       prev_m1;

    // Reset held with both masters requesting
    reset_n = 1'b0;
    drv0(1'b1, 1'b0, 8'h04, 4'hF, 32'h0);
    drv1(1'b1, 1'b0, 8'h84, 4'hF, 32'h0);
    tick(); tick(); #2;
    chk("rst_wait0", 32'(m0_waitrequest), 32'd1);
    chk("rst_wait1", 32'(m1_waitrequest), 32'd1);
    chk("rst_cs", 32'(sram_chipselect), 32'd0);
    chk("rst_wr", 32'(sram_write), 32'd0);
    chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);

    // Release: first contended grant goes to m0
    tick();
    reset_n = 1'b1;
    #2;
    chk("rel_wait0", 32'(m0_waitrequest), 32'd0);
    chk("rel_wait1", 32'(m1_waitrequest), 32'd1);
    chk("rel_addr", 32'(sram_address), 32'h04);
    tick();
    drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    #2;
    chk("rel_rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("rel_rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("rel_data", m0_readdata, dflt(8'h04));

    // Single master write then read-after-write
    tick();
    drv0(1'b0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
    #2;
    chk("sw_wait0", 32'(m0_waitrequest), 32'd0);
    chk("sw_wait1", 32'(m1_waitrequest), 32'd0);
    chk("sw_cs", 32'(sram_chipselect), 32'd1);
    chk("sw_wr", 32'(sram_write), 32'd1);
    tick();
    drv0(1'b1, 1'b0, 8'h10, 4'hF, 32'h0);
    #2;
    chk("sr_wait0", 32'(m0_waitrequest), 32'd0);
    chk("sr_wr", 32'(sram_write), 32'd0);
    chk("sr_rdv0_early", 32'(m0_readdatavalid), 32'd0);
    tick();
    drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    #2;
    chk("sr_rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("sr_data", m0_readdata, 32'hDEADBEEF);
    chk("sr_rdv1", 32'(m1_readdatavalid), 32'd0);

    // Byte lanes from m1
    tick();
    drv1(1'b0, 1'b1, 8'h20, 4'hF, 32'h11223344);
    tick();
    drv1(1'b0, 1'b1, 8'h20, 4'h5, 32'hAABBCCDD);
    tick();
    drv1(1'b1, 1'b0, 8'h20, 4'hF, 32'h0);
    tick();
    drv1(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    #2;
    chk("be_rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("be_rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("be_data", m1_readdata, 32'h11BB33DD);

    // Continuous contention: m0 @0x00.., m1 @0x80.., alternating from m0
    idx0 = 8'h00; idx1 = 8'h00; prev_addr = 8'h00; prev_m1 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k < 8) begin
        drv0(1'b1, 1'b0, idx0, 4'hF, 32'h0);
        drv1(1'b1, 1'b0, 8'h80 + idx1, 4'hF, 32'h0);
      end else begin
        drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
        drv1(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
      end
      #2;
      if (k < 8) begin
        chk($sformatf("ct_wait0_%0d", k), 32'(m0_waitrequest), (k % 2 == 0) ? 32'd0 : 32'd1);
        chk($sformatf("ct_wait1_%0d", k), 32'(m1_waitrequest), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("ct_addr_%0d", k), 32'(sram_address),
            (k % 2 == 0) ? 32'(idx0) : 32'(8'h80 + idx1));
      end
      if (k > 0) begin
        chk($sformatf("ct_rdv0_%0d", k), 32'(m0_readdatavalid), prev_m1 ? 32'd0 : 32'd1);
        chk($sformatf("ct_rdv1_%0d", k), 32'(m1_readdatavalid), prev_m1 ? 32'd1 : 32'd0);
        chk($sformatf("ct_data_%0d", k), prev_m1 ? m1_readdata : m0_readdata, dflt(prev_addr));
      end
      if (k % 2 == 0) begin
        prev_m1 = 1'b0; prev_addr = idx0; idx0 = idx0 + 8'd1;
      end else begin
        prev_m1 = 1'b1; prev_addr = 8'h80 + idx1; idx1 = idx1 + 8'd1;
      end
    end

    // Read and write asserted together act as a write
    drv0(1'b1, 1'b1, 8'h30, 4'hF, 32'h00000055);
    #2;
    chk("rw_cs", 32'(sram_chipselect), 32'd1);
    chk("rw_wr", 32'(sram_write), 32'd1);
    tick();
    drv0(1'b1, 1'b0, 8'h30, 4'hF, 32'h0);
    #2;
    chk("rw_no_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    tick();
    drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    #2;
    chk("rw_rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("rw_data", m0_readdata, 32'h00000055);

    // Reset pulsed while an m1 read is in flight
    tick();
    drv1(1'b1, 1'b0, 8'h20, 4'hF, 32'h0);
    tick();
    drv1(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_rdv1_rst", 32'(m1_readdatavalid), 32'd0);
    chk("mr_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("mr_cs", 32'(sram_chipselect), 32'd0);
    #1;
    reset_n = 1'b1;
    tick();
    #2;
    chk("mr_rdv1_after", 32'(m1_readdatavalid), 32'd0);
    // Contend with m0 having been granted last, so only a reset of last_grant favours m0
    drv0(1'b1, 1'b0, 8'h01, 4'hF, 32'h0);
    tick();
    drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    drv0(1'b1, 1'b0, 8'h02, 4'hF, 32'h0);
    drv1(1'b1, 1'b0, 8'h82, 4'hF, 32'h0);
    #1;
    chk("mr_lg_wait0", 32'(m0_waitrequest), 32'd0);
    chk("mr_lg_wait1", 32'(m1_waitrequest), 32'd1);
    tick();
    drv0(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    drv1(1'b0, 1'b0, 8'h00, 4'h0, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-master round-robin arbiter sharing one 256×32 port of the on-chip dual-port SRAM between two Avalon-MM masters (e.g. pixel-fill engine and HPS bridge). Issues at most one access per clock to the SRAM port, stalls the loser with `waitrequest`, and returns read data with a registered `readdatavalid` tagged to the issuing master. Sits between the masters and the SRAM slave port (`chipselect`/`write`/`byteenable`, unregistered output, one-cycle read latency).

## Interface
- `ADDR_W`, 8, word address width (256 words)
- `DATA_W`, 32, data width
- `BE_W`, 4, byteenable width (`DATA_W/8`)
- `clk`  in  1  sole clock; the SRAM port runs on this clock
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_address` / `m1_address`  in  ADDR_W  word address
- `m0_byteenable` / `m1_byteenable`  in  BE_W  byte lanes for writes
- `m0_read` / `m1_read`  in  1  read request
- `m0_write` / `m1_write`  in  1  write request
- `m0_writedata` / `m1_writedata`  in  DATA_W  write data
- `m0_waitrequest` / `m1_waitrequest`  out  1  request not accepted this cycle; hold
- `m0_readdata` / `m1_readdata`  out  DATA_W  read data, valid with `readdatavalid`
- `m0_readdatavalid` / `m1_readdatavalid`  out  1  one-cycle pulse per accepted read
- `sram_address`  out  ADDR_W  to SRAM port
- `sram_byteenable`  out  BE_W  to SRAM port
- `sram_chipselect`  out  1  access issued this cycle
- `sram_write`  out  1  issued access is a write
- `sram_writedata`  out  DATA_W  to SRAM port
- `sram_readdata`  in  DATA_W  SRAM output, valid one cycle after address issued

## Operation
- Request from master i: `mi_read | mi_write`. Both asserted together → treated as write; no `readdatavalid` generated.
- State: `last_grant` (1 bit, reset 1), `rd_pend` (reset 0), `rd_owner` (reset 0).
- Grant (combinational, same cycle):
  - Only one master requests → that master is granted.
  - Both request → grant `~last_grant`.
  - None → no grant; `sram_chipselect`=0.
- Granted master's address, byteenable, writedata, and write are muxed onto `sram_*`; `sram_chipselect`=1.
- When idle, `sram_*` data and address outputs drive master 0's values; these are don't-care because `sram_chipselect`=0.
- `mi_waitrequest` = request_i & ~grant_i. A master with no request sees 0.
- On every grant: `last_grant` ← granted index.
- On a granted read: `rd_pend` ← 1 and `rd_owner` ← index. Otherwise `rd_pend` ← 0.
- Return path: `mi_readdatavalid` = `rd_pend & (rd_owner==i)`, registered.
  - `mi_readdata` = `sram_readdata` for both masters; it is only meaningful while valid.
- Back-to-back reads from one or both masters are fully pipelined: one read per cycle, one valid per cycle.
- Writes produce no response.
- Read-after-write to the same address, issued on consecutive cycles, returns the new data (same-port write-then-read).
- Reset (asynchronous, any time):
  - `last_grant`=1, `rd_pend`=0.
  - Both `waitrequest` forced to 1 while `reset_n`=0.
  - `sram_chipselect`=0, `sram_write`=0, both `readdatavalid`=0.
  - A read in flight when reset asserts never produces `readdatavalid`.

## Timing
- Acceptance latency: 0 cycles when uncontended.
- Contended: the loser waits exactly 1 cycle if the winner drops its request, otherwise grants alternate every cycle.
- Read latency: accepted on edge N → `readdatavalid` high for exactly the cycle after N, data = `sram_readdata` in that cycle.
- Throughput: 1 access/cycle aggregate.
- Each master gets ≥1 grant per 2 cycles under continuous contention (no starvation).
- Outputs after reset release:
  - `waitrequest` follows request and grant combinationally from the first cycle.
  - First contended grant goes to m0.

## Test plan
- Reset: hold `reset_n`=0 with both masters requesting.
  - → both `waitrequest`=1, `sram_chipselect`=0, no `readdatavalid`.
  - Release → first grant m0.
- Single master: m0 writes 0xDEADBEEF @0x10 with be=0xF, then reads @0x10 the next cycle.
  - → `waitrequest`=0 both cycles.
  - → `m0_readdatavalid` 1 cycle later with 0xDEADBEEF.
  - → `m1_readdatavalid` stays 0.
- Contention: both masters issue continuous reads (m0 @0x00..0x03, m1 @0x80..0x83) for 8 cycles.
  - → grants alternate m0,m1,m0,…; each stalled cycle shows `waitrequest`=1.
  - → 8 valids returned in issue order to the correct master with the correct data.
- Byte lanes: preload 0x11223344 @0x20; m1 writes 0xAABBCCDD with be=0x5; m1 reads @0x20.
  - → 0x11BB33DD.
- Read+write together: m0 asserts read and write with 0x55 @0x30.
  - → write performed, no `readdatavalid`; a subsequent read returns 0x55.
- Reset mid-read: m1 read accepted, `reset_n` pulsed low before the next edge.
  - → no `m1_readdatavalid`; `last_grant` returns to 1.
